// File: rtl/ddr_port_arbiter_pkg.sv
// Shared definitions for the DDR read-port arbiter.
// Contents:
//   - requester index constants (instruction, feature and weight fetchers)
//   - FSM state encoding for the burst issuer
//   - return-tag record carried by the fixed-latency tag pipeline
//   - default memory read latency
package ddr_port_arbiter_pkg;

  localparam int ARB_REQ_INSTR   = 0;
  localparam int ARB_REQ_FEATURE = 1;
  localparam int ARB_REQ_WEIGHT  = 2;

  localparam int ARB_NUM_REQ     = 3;
  localparam int ARB_ID_WIDTH    = 2;
  localparam int ARB_RD_LATENCY  = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // One entry per issued beat: who owns it and whether it closes the burst.
  typedef struct packed {
    logic                    vld;
    logic [ARB_ID_WIDTH-1:0] id;
    logic                    last;
  } arb_tag_t;

endpackage

// File: rtl/ddr_port_arbiter_rr_arbiter.sv
// Combinational round-robin winner select.
// The search starts at the index just after ptr (the previous winner) and
// wraps modulo N, so the previous winner has the lowest priority.
// Ports:
//   req       in   N     request vector
//   ptr       in   ID_W  index of the previous winner
//   grant     out  N     one-hot winner (all zero when nothing requests)
//   id        out  ID_W  encoded winner index
//   any_grant out  1     at least one request present
module rr_arbiter #(
  parameter int N    = 3,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id,
  output logic            any_grant
);

  // NOTE: every output gets a default before the search loop; without it a
  // cycle with no request would leave the outputs holding, i.e. a latch.
  always_comb begin
    grant     = '0;
    id        = '0;
    any_grant = 1'b0;
    // Visit candidates in priority order ptr+1, ptr+2, ... ptr+N (mod N);
    // the first asserted one wins.
    for (int off = 1; off <= N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!any_grant && req[i] && (i == (int'(ptr) + off) % N)) begin
          grant[i]  = 1'b1;
          id        = ID_W'(i);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one external read port between the instruction, feature and weight
// fetchers. Whole bursts are granted round-robin; each beat's owner travels
// through a RD_LATENCY-deep tag pipeline so returning data is steered to the
// right requester even when a new burst has already started issuing.
// Ports:
//   clk        in   1                    clock
//   rst        in   1                    asynchronous reset, active low
//   req_valid  in   NUM_REQ              burst request, held until accepted
//   req_addr   in   NUM_REQ*ADDR_WIDTH   packed start addresses
//   req_len    in   NUM_REQ*LEN_WIDTH    packed burst length minus one
//   req_ready  out  NUM_REQ              one-hot acceptance pulse
//   rsp_valid  out  NUM_REQ              one-hot owner of the beat on rsp_data
//   rsp_last   out  1                    final beat of the returning burst
//   rsp_data   out  DATA_WIDTH           returned data (shared)
//   mem_addr   out  ADDR_WIDTH           external read address
//   mem_rd_en  out  1                    external read strobe
//   mem_rdata  in   DATA_WIDTH           external read data
//   busy       out  1                    issuing or data still in flight
//   grant_id   out  2                    current or most recent owner
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 4,
  parameter int RD_LATENCY = ARB_RD_LATENCY   // must be >= 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic                            rsp_last,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_rd_en,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            busy,
  output logic [ARB_ID_WIDTH-1:0]         grant_id
);

  arb_state_e              state_q, state_d;
  logic [ARB_ID_WIDTH-1:0] rr_ptr_q;
  logic [ARB_ID_WIDTH-1:0] grant_id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    beat_cnt_q;

  logic [NUM_REQ-1:0]      win_grant;
  logic [ARB_ID_WIDTH-1:0] win_id;
  logic                    win_any;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LEN_WIDTH-1:0]    sel_len;
  logic                    accept;
  logic                    last_beat;

  arb_tag_t                tag_q [RD_LATENCY];
  arb_tag_t                tag_in;
  arb_tag_t                tag_out;
  logic                    tag_any_vld;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ARB_ID_WIDTH)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (win_grant),
    .id        (win_id),
    .any_grant (win_any)
  );

  // Pick the winner's start address and length out of the packed buses.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Next-state logic. Acceptance is also gated by rst so that req_ready
  // stays low for the whole time reset is held.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (win_any && rst) begin
          accept  = 1'b1;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (beat_cnt_q == '0) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign req_ready = accept ? win_grant : '0;
  assign mem_rd_en = (state_q == ARB_BURST);
  assign mem_addr  = mem_rd_en ? addr_q : '0;
  assign last_beat = mem_rd_en && (beat_cnt_q == '0);
  assign grant_id  = grant_id_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= ARB_ID_WIDTH'(NUM_REQ - 1);
      grant_id_q <= '0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= sel_addr;
        beat_cnt_q <= sel_len;
        grant_id_q <= win_id;
        rr_ptr_q   <= win_id;
      end else if (mem_rd_en) begin
        // Address wraps naturally modulo 2^ADDR_WIDTH.
        addr_q     <= addr_q + ADDR_WIDTH'(1);
        beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);
      end
    end
  end

  // Tag pipeline: one stage per cycle of memory latency, so the tag of the
  // beat issued at cycle t is at the output exactly when its data arrives.
  assign tag_in = '{vld: mem_rd_en, id: grant_id_q, last: last_beat};

  // NOTE: this shift register must be reset (unlike a plain data RAM): a
  // stale vld bit would claim returning data for a burst reset abandoned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[RD_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_out.vld && (tag_out.id == ARB_ID_WIDTH'(i))) rsp_valid[i] = 1'b1;
    end
  end

  always_comb begin
    tag_any_vld = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) tag_any_vld = tag_any_vld | tag_q[i].vld;
  end

  assign rsp_last = tag_out.vld & tag_out.last;
  assign rsp_data = mem_rdata;
  assign busy     = mem_rd_en | tag_any_vld;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a transaction-level schedule model.
module tb_ddr_port_arbiter;
  import ddr_port_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 128;
  localparam int LW = 4;
  localparam int RL = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic             rsp_last;
  logic [DW-1:0]    rsp_data;
  logic [AW-1:0]    mem_addr;
  logic             mem_rd_en;
  logic [DW-1:0]    mem_rdata;
  logic             busy;
  logic [1:0]       grant_id;

  always #5 clk = ~clk;

  ddr_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_last(rsp_last), .rsp_data(rsp_data), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data is a fixed function of the address, returned RL cycles later.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {8{a ^ 16'h5A3C}};
  endfunction

  logic [AW-1:0] mem_pipe [RL];
  always @(posedge clk) begin
    mem_pipe[0] <= mem_addr;
    for (int i = 1; i < RL; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_rdata = data_of(mem_pipe[RL-1]);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- schedule model ----------------
  int            m_next_free, m_bs, m_be, m_last, m_gid;
  logic [AW-1:0] m_baddr;
  int            exp_rsp_id   [int];
  bit            exp_rsp_last [int];
  logic [AW-1:0] exp_rsp_addr [int];

  function automatic void model_reset();
    m_next_free = 0;
    m_bs        = 1;
    m_be        = 0;
    m_last      = NR - 1;
    m_gid       = 0;
    m_baddr     = '0;
    exp_rsp_id.delete();
    exp_rsp_last.delete();
    exp_rsp_addr.delete();
  endfunction

  always @(negedge clk) begin : cmp
    bit            in_b, e_busy;
    logic [NR-1:0] e_ready;
    int            w, len;
    logic [AW-1:0] a;
    if (!rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_mem_rd_en", mem_rd_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_last", rsp_last, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
    end else begin
      in_b = (cyc >= m_bs) && (cyc <= m_be);
      check("mem_rd_en", mem_rd_en, in_b);
      check("mem_addr", mem_addr, in_b ? 16'(m_baddr + (cyc - m_bs)) : 16'h0);
      check("grant_id", grant_id, m_gid);
      e_busy = in_b;
      for (int k = 0; k < RL; k++) if (exp_rsp_id.exists(cyc + k)) e_busy = 1'b1;
      check("busy", busy, e_busy);
      if (exp_rsp_id.exists(cyc)) begin
        check("rsp_valid", rsp_valid, NR'(1) << exp_rsp_id[cyc]);
        check("rsp_last", rsp_last, exp_rsp_last[cyc]);
        check("rsp_data", rsp_data, data_of(exp_rsp_addr[cyc]));
        exp_rsp_id.delete(cyc);
        exp_rsp_last.delete(cyc);
        exp_rsp_addr.delete(cyc);
      end else begin
        check("rsp_valid_idle", rsp_valid, 0);
        check("rsp_last_idle", rsp_last, 0);
      end
      e_ready = '0;
      if (cyc >= m_next_free && req_valid != '0) begin
        w = -1;
        for (int off = 1; off <= NR; off++)
          if (w < 0 && req_valid[(m_last + off) % NR]) w = (m_last + off) % NR;
        len = int'(req_len[w*LW +: LW]);
        a   = req_addr[w*AW +: AW];
        e_ready[w]  = 1'b1;
        m_bs        = cyc + 1;
        m_be        = cyc + 1 + len;
        m_baddr     = a;
        m_next_free = cyc + 2 + len;
        m_gid       = w;
        m_last      = w;
        for (int k = 0; k <= len; k++) begin
          exp_rsp_id[cyc + 1 + k + RL]   = w;
          exp_rsp_last[cyc + 1 + k + RL] = (k == len);
          exp_rsp_addr[cyc + 1 + k + RL] = 16'(a + k);
        end
      end
      check("req_ready", req_ready, e_ready);
    end
  end

  // ---------------- driver and event logs ----------------
  typedef struct { int cyc; int id; }                           gent_t;
  typedef struct { int cyc; logic [AW-1:0] addr; }              aent_t;
  typedef struct { int cyc; logic [NR-1:0] v; logic last; }     rent_t;
  gent_t      glog [$];
  aent_t      alog [$];
  rent_t      rlog [$];
  bit         busy_log [int];
  logic [NR-1:0] hold = '0;

  task automatic clear_logs();
    glog.delete();
    alog.delete();
    rlog.delete();
  endtask

  // One clock per iteration: sample at the falling edge, update inputs 1ns
  // after the rising edge. Accepted requests drop unless held.
  task automatic step(input int n);
    logic [NR-1:0] hit;
    repeat (n) begin
      @(negedge clk);
      hit = req_valid & req_ready;
      for (int i = 0; i < NR; i++) if (hit[i]) glog.push_back(gent_t'{cyc, i});
      if (mem_rd_en) alog.push_back(aent_t'{cyc, mem_addr});
      if (rsp_valid != '0) rlog.push_back(rent_t'{cyc, rsp_valid, rsp_last});
      busy_log[cyc] = busy;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (hit[i] && !hold[i]) req_valid[i] = 1'b0;
    end
  endtask

  task automatic post(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_grants(input string name, input int n);
    int b = 0;
    while (glog.size() < n && b < 80) begin
      step(1);
      b++;
    end
    check({name, "_grant_timeout"}, glog.size() >= n, 1);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    model_reset();
    req_valid = '0;
    hold      = '0;
    step(2);
    rst       = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int t;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    model_reset();
    #2 rst = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_mem_rd_en", mem_rd_en, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_mem_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single burst: requester 1, 0x0100, 4 beats.
    clear_logs();
    post(ARB_REQ_FEATURE, 16'h0100, 4'd3);
    wait_grants("single", 1);
    t = glog[0].cyc;
    check("single_id", glog[0].id, 1);
    step(8);
    check("single_nbeats", alog.size(), 4);
    for (int k = 0; k < 4 && k < alog.size(); k++) begin
      check("single_addr", alog[k].addr, 16'h0100 + k);
      check("single_beat_cyc", alog[k].cyc, t + 1 + k);
    end
    check("single_nrsp", rlog.size(), 4);
    for (int k = 0; k < 4 && k < rlog.size(); k++) begin
      check("single_rsp_cyc", rlog[k].cyc, t + 3 + k);
      check("single_rsp_owner", rlog[k].v, 3'b010);
      check("single_rsp_last", rlog[k].last, k == 3);
    end
    check("single_busy_t6", busy_log[t + 6], 1);
    check("single_busy_t7", busy_log[t + 7], 0);

    // All three at once after reset, single beats.
    do_reset();
    clear_logs();
    post(0, 16'h0010, 4'd0);
    post(1, 16'h0020, 4'd0);
    post(2, 16'h0030, 4'd0);
    wait_grants("all3", 3);
    step(6);
    for (int k = 0; k < 3 && k < glog.size(); k++) check("all3_order", glog[k].id, k);
    if (glog.size() >= 3) begin
      check("all3_gap1", glog[1].cyc - glog[0].cyc, 2);
      check("all3_gap2", glog[2].cyc - glog[0].cyc, 4);
    end
    check("all3_nrsp", rlog.size(), 3);
    for (int k = 0; k < 3 && k < rlog.size() && k < glog.size(); k++) begin
      check("all3_rsp_owner", rlog[k].v, 3'b001 << k);
      check("all3_rsp_cyc", rlog[k].cyc, glog[k].cyc + 1 + RL);
    end

    // Fairness: 0 and 2 held continuously, 2-beat bursts.
    do_reset();
    clear_logs();
    hold = 3'b101;
    post(0, 16'h0400, 4'd1);
    post(2, 16'h0800, 4'd1);
    wait_grants("fair", 6);
    hold      = '0;
    req_valid = '0;
    step(8);
    for (int k = 0; k < 6 && k < glog.size(); k++) begin
      check("fair_order", glog[k].id, (k % 2 == 0) ? 0 : 2);
      if (k > 0) check("fair_gap", glog[k].cyc - glog[k-1].cyc, 3);
    end

    // Address wrap.
    clear_logs();
    post(ARB_REQ_WEIGHT, 16'hFFFE, 4'd3);
    wait_grants("wrap", 1);
    step(6);
    check("wrap_nbeats", alog.size(), 4);
    if (alog.size() >= 4) begin
      check("wrap_a0", alog[0].addr, 16'hFFFE);
      check("wrap_a1", alog[1].addr, 16'hFFFF);
      check("wrap_a2", alog[2].addr, 16'h0000);
      check("wrap_a3", alog[3].addr, 16'h0001);
    end

    // Overlap: second grant issues while the first beat is still in flight.
    clear_logs();
    post(0, 16'h00A0, 4'd0);
    post(1, 16'h00B0, 4'd0);
    wait_grants("ovl", 2);
    step(6);
    check("ovl_nrsp", rlog.size(), 2);
    if (rlog.size() >= 2 && glog.size() >= 2) begin
      check("ovl_id0", glog[0].id, 0);
      check("ovl_id1", glog[1].id, 1);
      check("ovl_rsp_gap", rlog[1].cyc - rlog[0].cyc, 2);
      check("ovl_inflight", glog[1].cyc < rlog[0].cyc, 1);
      check("ovl_owner0", rlog[0].v, 3'b001);
      check("ovl_owner1", rlog[1].v, 3'b010);
    end

    // Reset during beat 2 of an 8-beat burst.
    clear_logs();
    post(1, 16'h0200, 4'd7);
    wait_grants("rstmid", 1);
    step(1);
    rst = 1'b0;
    model_reset();
    #1;
    check("rstmid_rd_en", mem_rd_en, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_addr", mem_addr, 0);
    check("rstmid_grant_id", grant_id, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    #2 rst = 1'b1;
    step(4);
    check("rstmid_discard", rlog.size(), 0);
    post(0, 16'h0300, 4'd0);
    post(1, 16'h0310, 4'd0);
    post(2, 16'h0320, 4'd0);
    wait_grants("rstmid_after", 4);
    if (glog.size() >= 2) check("rstmid_first_after", glog[1].id, 0);
    step(6);

    // Randomized traffic, including withdrawals and near-wrap addresses.
    clear_logs();
    for (int n = 0; n < 1500; n++) begin
      step(1);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(3) == 0)
            post(i,
                 ($urandom_range(3) == 0) ? 16'(16'hFFF0 + $urandom_range(15)) : 16'($urandom),
                 ($urandom_range(1) == 0) ? 4'($urandom_range(3)) : 4'($urandom_range(15)));
        end else if ($urandom_range(31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    step(24);
    check("rand_activity", glog.size() > 50, 1);
    check("rand_drained", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
